read_arbiter_core: RTL and testbench

READ_ARBITER_CORE -- requirements
Module: read_arbiter_core

---
 rtl/read_arb_pkg.sv | 14 +
 rtl/read_arbiter_core_rr_picker.sv | 25 ++
 rtl/read_arbiter_core.sv | 127 ++++++++++++
 tb/tb_read_arbiter_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_arb_pkg.sv
// Shared constants and FSM encoding for the output-port read arbiter.
package read_arb_pkg;

  localparam int unsigned NUM_QUEUES = 8;
  localparam int unsigned WEIGHT_W   = 4;
  localparam int unsigned SEL_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2
  } state_t;

endpackage

// File: rtl/read_arbiter_core_rr_picker.sv
// Combinational find-first-set over an eligibility vector, searching upward
// from a rotating start index and wrapping at N-1.
module rr_picker #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      automatic int unsigned pos = (int'(i_start) + k) % N;
      if (!o_found && i_req[pos]) begin
        o_idx   = IDX_W'(pos);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/read_arbiter_core.sv
// Per-port read arbiter: strict-priority or credit-based WRR queue selection
// with an IDLE/GRANT/XFER handshake toward the packet read engine.
module read_arbiter_core #(
  parameter int unsigned NUM_QUEUES = 8,
  parameter int unsigned WEIGHT_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sp0_wrr1,
  input  logic [NUM_QUEUES-1:0]          q_valid,
  input  logic [NUM_QUEUES*WEIGHT_W-1:0] weight_in,
  input  logic                           rd_ack,
  input  logic                           rd_eop,
  output logic [2:0]                     select,
  output logic                           grant_valid,
  output logic                           transfering
);

  import read_arb_pkg::*;

  state_t                r_state;
  logic [SEL_W-1:0]      r_select;
  logic [SEL_W-1:0]      r_rr_ptr;
  logic                  r_grant_valid;
  logic                  r_transfering;
  logic [WEIGHT_W-1:0]   r_credit [NUM_QUEUES];

  logic [WEIGHT_W-1:0]   w_wt_eff [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] w_elig;
  logic [NUM_QUEUES-1:0] w_pick_req;
  logic                  w_any_elig;
  logic                  w_reload;
  logic [SEL_W-1:0]      w_rr_idx;
  logic                  w_rr_found;
  logic [SEL_W-1:0]      w_sp_idx;
  logic [SEL_W-1:0]      w_next_sel;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      w_wt_eff[i] = weight_in[i*WEIGHT_W +: WEIGHT_W];
      if (w_wt_eff[i] == '0) w_wt_eff[i] = WEIGHT_W'(1);
      w_elig[i] = q_valid[i] && (r_credit[i] != '0);
    end
  end

  // With every credit exhausted the pick runs against freshly reloaded
  // credits; since effective weights are never 0 that is just q_valid.
  assign w_any_elig = |w_elig;
  assign w_pick_req = w_any_elig ? w_elig : q_valid;
  assign w_reload   = sp0_wrr1 && !w_any_elig;

  rr_picker #(
    .N     (NUM_QUEUES),
    .IDX_W (SEL_W)
  ) u_rr_picker (
    .i_req   (w_pick_req),
    .i_start (r_rr_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  always_comb begin
    w_sp_idx = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (q_valid[i]) w_sp_idx = SEL_W'(i);
    end
  end

  assign w_next_sel = (sp0_wrr1 && w_rr_found) ? w_rr_idx : w_sp_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_select      <= '0;
      r_rr_ptr      <= '0;
      r_grant_valid <= 1'b0;
      r_transfering <= 1'b0;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) r_credit[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|q_valid) begin
            r_select      <= w_next_sel;
            r_grant_valid <= 1'b1;
            r_state       <= S_GRANT;
            if (w_reload) begin
              for (int unsigned i = 0; i < NUM_QUEUES; i++) r_credit[i] <= w_wt_eff[i];
            end
          end
        end
        S_GRANT: begin
          if (rd_ack) begin
            if (r_credit[r_select] != '0) r_credit[r_select] <= r_credit[r_select] - 1'b1;
            r_rr_ptr      <= (r_select == SEL_W'(NUM_QUEUES - 1)) ? '0 : r_select + 1'b1;
            r_grant_valid <= 1'b0;
            if (rd_eop) begin
              r_state <= S_IDLE;
            end else begin
              r_state       <= S_XFER;
              r_transfering <= 1'b1;
            end
          end else if (!q_valid[r_select]) begin
            r_grant_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_XFER: begin
          if (rd_eop) begin
            r_transfering <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_grant_valid <= 1'b0;
          r_transfering <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign select      = r_select;
  assign grant_valid = r_grant_valid;
  assign transfering = r_transfering;

endmodule

// File: tb/tb_read_arbiter_core.sv
// Directed bench for read_arbiter_core: strict and WRR ordering, handshake
// timing, grant withdrawal and asynchronous reset.
module tb_read_arbiter_core;

  logic        clk;
  logic        rst;
  logic        sp0_wrr1;
  logic [7:0]  q_valid;
  logic [31:0] weight_in;
  logic        rd_ack;
  logic        rd_eop;
  logic [2:0]  select;
  logic        grant_valid;
  logic        transfering;

  int checks = 0;
  int errors = 0;

  read_arbiter_core #(
    .NUM_QUEUES (8),
    .WEIGHT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sp0_wrr1    (sp0_wrr1),
    .q_valid     (q_valid),
    .weight_in   (weight_in),
    .rd_ack      (rd_ack),
    .rd_eop      (rd_eop),
    .select      (select),
    .grant_valid (grant_valid),
    .transfering (transfering)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; sp0_wrr1 = 1'b0; q_valid = '0; weight_in = '0;
    rd_ack = 1'b0; rd_eop = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    step();
    checks++;
    if (select !== 3'd0 || grant_valid !== 1'b0 || transfering !== 1'b0) begin
      errors++;
      $display("FAIL reset_state sel=%0d gv=%0b tr=%0b expected 0/0/0", select, grant_valid, transfering);
    end
    rst = 1'b1;
    rd_ack = 1'b1; rd_eop = 1'b1;
    step(); step();
    checks++;
    if (grant_valid !== 1'b0 || transfering !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_ack_eop gv=%0b tr=%0b expected 0/0", grant_valid, transfering);
    end
    rd_ack = 1'b0; rd_eop = 1'b0;
  endtask

  task automatic test_strict();
    do_reset();
    q_valid = 8'b1000_0101;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd7) begin
      errors++;
      $display("FAIL strict_first gv=%0b sel=%0d expected gv=1 sel=7", grant_valid, select);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    checks++;
    if (transfering !== 1'b1 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL strict_xfer tr=%0b gv=%0b expected tr=1 gv=0", transfering, grant_valid);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (transfering !== 1'b1 || select !== 3'd7) begin
      errors++;
      $display("FAIL strict_xfer_hold tr=%0b sel=%0d expected tr=1 sel=7", transfering, select);
    end
    rd_eop = 1'b1;
    step();
    rd_eop = 1'b0;
    checks++;
    if (transfering !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL strict_idle_gap tr=%0b gv=%0b expected 0/0", transfering, grant_valid);
    end
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd7) begin
      errors++;
      $display("FAIL strict_next gv=%0b sel=%0d expected gv=1 sel=7", grant_valid, select);
    end
    // A mode change while granted must not disturb the held selection.
    sp0_wrr1 = 1'b1;
    step(); step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd7) begin
      errors++;
      $display("FAIL mode_change_hold gv=%0b sel=%0d expected gv=1 sel=7", grant_valid, select);
    end
  endtask

  task automatic test_wrr_order();
    int exp_q [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0};
    do_reset();
    sp0_wrr1  = 1'b1;
    weight_in = 32'h3111_1111;
    q_valid   = 8'hFF;
    step();
    for (int p = 0; p < 11; p++) begin
      checks++;
      if (grant_valid !== 1'b1 || select !== 3'(exp_q[p])) begin
        errors++;
        $display("FAIL wrr_order[%0d] gv=%0b sel=%0d expected gv=1 sel=%0d", p, grant_valid, select, exp_q[p]);
      end
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      checks++;
      if (transfering !== 1'b1 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL wrr_xfer[%0d] tr=%0b gv=%0b expected tr=1 gv=0", p, transfering, grant_valid);
      end
      rd_eop = 1'b1;
      step();
      rd_eop = 1'b0;
      checks++;
      if (grant_valid !== 1'b0 || transfering !== 1'b0) begin
        errors++;
        $display("FAIL wrr_gap[%0d] gv=%0b tr=%0b expected 0/0", p, grant_valid, transfering);
      end
      step();
    end
  endtask

  task automatic test_zero_weight();
    do_reset();
    sp0_wrr1  = 1'b1;
    weight_in = 32'h0000_0000;
    q_valid   = 8'h08;
    step();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (grant_valid !== 1'b1 || select !== 3'd3) begin
        errors++;
        $display("FAIL zero_weight[%0d] gv=%0b sel=%0d expected gv=1 sel=3", p, grant_valid, select);
      end
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      rd_eop = 1'b1;
      step();
      rd_eop = 1'b0;
      step();
    end
  endtask

  task automatic test_ack_eop();
    // Continues from test_zero_weight: queue 3 granted.
    rd_ack = 1'b1; rd_eop = 1'b1;
    step();
    rd_ack = 1'b0; rd_eop = 1'b0;
    checks++;
    if (transfering !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_eop_idle tr=%0b gv=%0b expected 0/0", transfering, grant_valid);
    end
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd3 || transfering !== 1'b0) begin
      errors++;
      $display("FAIL ack_eop_next gv=%0b sel=%0d tr=%0b expected gv=1 sel=3 tr=0", grant_valid, select, transfering);
    end
  endtask

  task automatic test_drop();
    do_reset();
    sp0_wrr1  = 1'b1;
    weight_in = 32'h1111_1111;
    q_valid   = 8'h06;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd1) begin
      errors++;
      $display("FAIL drop_first gv=%0b sel=%0d expected gv=1 sel=1", grant_valid, select);
    end
    q_valid = 8'h04;
    step();
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_gv gv=%0b expected 0", grant_valid);
    end
    // No charge and no pointer move: queue 1 still has credit from pointer 0.
    q_valid = 8'h06;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd1) begin
      errors++;
      $display("FAIL drop_regrant gv=%0b sel=%0d expected gv=1 sel=1", grant_valid, select);
    end
    rd_ack = 1'b1; rd_eop = 1'b1;
    step();
    rd_ack = 1'b0; rd_eop = 1'b0;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd2) begin
      errors++;
      $display("FAIL drop_after_charge gv=%0b sel=%0d expected gv=1 sel=2", grant_valid, select);
    end
  endtask

  task automatic test_reset_mid_xfer();
    // Continues from test_drop: queue 2 granted.
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    checks++;
    if (transfering !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_xfer tr=%0b expected 1", transfering);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (select !== 3'd0 || grant_valid !== 1'b0 || transfering !== 1'b0) begin
      errors++;
      $display("FAIL async_reset sel=%0d gv=%0b tr=%0b expected 0/0/0", select, grant_valid, transfering);
    end
    step();
    rst = 1'b1;
    q_valid = 8'hFF;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_first gv=%0b sel=%0d expected gv=1 sel=0", grant_valid, select);
    end
    rd_ack = 1'b1; rd_eop = 1'b1;
    step();
    rd_ack = 1'b0; rd_eop = 1'b0;
    step();
    checks++;
    if (grant_valid !== 1'b1 || select !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_second gv=%0b sel=%0d expected gv=1 sel=1", grant_valid, select);
    end
  endtask

  initial begin
    test_reset();
    test_strict();
    test_wrr_order();
    test_zero_weight();
    test_ack_eop();
    test_drop();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (rst && grant_valid && transfering) begin
      checks++;
      errors++;
      $display("FAIL onehot gv=%0b tr=%0b expected not both 1", grant_valid, transfering);
    end
  end

endmodule
